// File: rtl/bcd_serial_adder_if.sv
// Handshake and data bundle for the digit-serial BCD adder.
// The master drives the request and operands; the slave returns the result and status.
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;
  logic                  busy;
  logic                  done;

  modport master (
    output start, a, b, cin,
    input  sum, cout, err, busy, done
  );

  modport slave (
    input  start, a, b, cin,
    output sum, cout, err, busy, done
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one decimal digit per clock, with operand
// validation at acceptance. Operands are latched when start is accepted in
// IDLE, so the request side may change freely while the block is busy.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_serial_adder_if.slave    bus
);

  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [4*DIGITS-1:0]   a_lat;
  logic [4*DIGITS-1:0]   b_lat;
  logic                  carry;
  logic [KW-1:0]         k;
  logic [4*DIGITS-1:0]   sum_val;
  logic                  cout_val;
  logic                  err_val;
  logic                  busy_val;
  logic                  done_val;
  logic                  ops_ok;
  logic [4:0]            digit_res;

  // True when every packed digit of v is in 0..9.
  function automatic logic digits_valid(input logic [4*DIGITS-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      ok = ok & (v[4*i +: 4] <= 4'd9);
    end
    return ok;
  endfunction

  // One decimal digit add: returns {carry, digit}; a binary result above 9
  // is corrected by +6, which wraps the nibble back into BCD.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] x,
                                                input logic [3:0] y,
                                                input logic       ci);
    logic [4:0] raw;
    logic [3:0] adj;
    raw = {1'b0, x} + {1'b0, y} + {4'd0, ci};
    adj = raw[3:0] + 4'd6;
    if (raw > 5'd9) begin
      return {1'b1, adj};
    end else begin
      return {1'b0, raw[3:0]};
    end
  endfunction

  // Operand validity and the digit currently being summed.
  always_comb begin
    ops_ok    = digits_valid(bus.a) & digits_valid(bus.b);
    digit_res = bcd_digit_add(a_lat[4*k +: 4], b_lat[4*k +: 4], carry);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: invalid operands skip ADD and go straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (ops_ok) begin
            state_next = ADD;
          end else begin
            state_next = DONE;
          end
        end else begin
          state_next = IDLE;
        end
      end
      ADD: begin
        if (k == K_LAST) begin
          state_next = DONE;
        end else begin
          state_next = ADD;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered status: latch on acceptance, one digit per ADD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_lat    <= '0;
      b_lat    <= '0;
      carry    <= 1'b0;
      k        <= '0;
      sum_val  <= '0;
      cout_val <= 1'b0;
      err_val  <= 1'b0;
      busy_val <= 1'b0;
      done_val <= 1'b0;
    end else begin
      busy_val <= (state_next != IDLE);
      done_val <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_lat    <= bus.a;
            b_lat    <= bus.b;
            carry    <= bus.cin;
            k        <= '0;
            sum_val  <= '0;
            cout_val <= 1'b0;
            err_val  <= ~ops_ok;
          end
        end
        ADD: begin
          sum_val[4*k +: 4] <= digit_res[3:0];
          carry             <= digit_res[4];
          if (k == K_LAST) begin
            cout_val <= digit_res[4];
            k        <= '0;
          end else begin
            k <= k + KW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.sum  = sum_val;
  assign bus.cout = cout_val;
  assign bus.err  = err_val;
  assign bus.busy = busy_val;
  assign bus.done = done_val;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder (DIGITS=4) with hand-computed results.
module tb_bcd_serial_adder;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  bcd_serial_adder_if #(.DIGITS(4)) bus ();

  bcd_serial_adder #(.DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when observed differs from expected.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One request: accept, scramble operands while busy, measure latency, check result and hold.
  task automatic do_add(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic [15:0] es, input logic ec,
                        input logic ee, input int elat);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    bus.a = av; bus.b = bv; bus.cin = ci; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 16'h8888; bus.b = 16'h8888; bus.cin = ~ci;
    cyc = 1;
    busy_cnt = 0;
    while (!bus.done && cyc < 20) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    if (bus.busy) busy_cnt++;
    check({tag, " latency"}, cyc, elat);
    check({tag, " busy_cycles"}, busy_cnt, elat);
    check({tag, " sum"}, {16'd0, bus.sum}, {16'd0, es});
    check({tag, " cout"}, {31'd0, bus.cout}, {31'd0, ec});
    check({tag, " err"}, {31'd0, bus.err}, {31'd0, ee});
    @(negedge clk);
    check({tag, " done_pulse_end"}, {31'd0, bus.done}, 32'd0);
    check({tag, " idle"}, {31'd0, bus.busy}, 32'd0);
    check({tag, " sum_hold"}, {16'd0, bus.sum}, {16'd0, es});
  endtask

  logic [15:0] res_sum [2];
  logic        res_cout [2];
  int          n_done;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.a     = 16'h1111;
    bus.b     = 16'h2222;
    bus.cin   = 1'b0;

    // Reset state, with start held high during reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset sum", {16'd0, bus.sum}, 32'd0);
    check("reset cout", {31'd0, bus.cout}, 32'd0);
    check("reset err", {31'd0, bus.err}, 32'd0);
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);

    do_add("1234+4321",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 5);
    do_add("9999+0001",   16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 5);
    do_add("9999+9999+1", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 5);
    do_add("0999+0000+1", 16'h0999, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0, 5);
    do_add("12A4 err",    16'h12A4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1);
    do_add("0005+0004",   16'h0005, 16'h0004, 1'b0, 16'h0009, 1'b0, 1'b0, 5);
    do_add("0000+B000",   16'h0000, 16'hB000, 1'b1, 16'h0000, 1'b0, 1'b1, 1);

    // start held for 10 edges, operands changed mid-operation: two results, back to back.
    n_done = 0;
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b0; bus.start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) begin
        bus.a = 16'h2000; bus.b = 16'h0500; bus.cin = 1'b1;
      end
      if (i == 9) bus.start = 1'b0;
      if (bus.done) begin
        if (n_done < 2) begin
          res_sum[n_done]  = bus.sum;
          res_cout[n_done] = bus.cout;
        end
        n_done++;
      end
    end
    check("held start done count", n_done, 32'd2);
    if (n_done >= 2) begin
      check("held start sum1", {16'd0, res_sum[0]}, 32'h5555);
      check("held start cout1", {31'd0, res_cout[0]}, 32'd0);
      check("held start sum2", {16'd0, res_sum[1]}, 32'h2501);
      check("held start cout2", {31'd0, res_cout[1]}, 32'd0);
    end

    // Reset asserted in the 2nd ADD cycle: immediate clear, no done pulse.
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset sum", {16'd0, bus.sum}, 32'd0);
    check("midreset busy", {31'd0, bus.busy}, 32'd0);
    check("midreset done", {31'd0, bus.done}, 32'd0);
    check("midreset cout", {31'd0, bus.cout}, 32'd0);
    check("midreset err", {31'd0, bus.err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("midreset no done", n_done, 32'd0);
    do_add("0005+0005", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, 5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
